// File: rtl/ndp_stream_sequencer.sv
// ndp_stream_sequencer: control path between AXI4-Stream and an external NDP
// compute unit. Fills a two-bank ping-pong scratch pad from s_axis, offers
// full banks to the compute unit, chains layers through a registered
// post-ReLU feedback buffer and streams the final result out on m_axis.
module ndp_stream_sequencer #(
    parameter int unsigned AXIS_W     = 32,
    parameter int unsigned ELEM_W     = 16,
    parameter int unsigned BANK_BEATS = 34,
    parameter int unsigned RES_ELEMS  = 64,
    parameter int unsigned LAYER_W    = 4
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [LAYER_W-1:0]                cfg_layers,
    input  logic [(2**LAYER_W)-1:0]           cfg_relu_mask,
    input  logic [AXIS_W-1:0]                 s_axis_tdata,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [AXIS_W-1:0]                 m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              buf_wen,
    output logic                              buf_bank,
    output logic [$clog2(BANK_BEATS)-1:0]     buf_waddr,
    output logic [AXIS_W-1:0]                 buf_wdata,
    output logic                              cu_bank_valid,
    output logic                              cu_bank,
    output logic [$clog2(BANK_BEATS+1)-1:0]   cu_bank_beats,
    output logic                              cu_bank_last,
    input  logic                              cu_bank_ack,
    output logic                              cu_feedback,
    input  logic                              cu_done,
    input  logic [RES_ELEMS*ELEM_W-1:0]       cu_result,
    output logic [RES_ELEMS*ELEM_W-1:0]       fb_data
);

    localparam int unsigned ADDR_W    = $clog2(BANK_BEATS);
    localparam int unsigned CNT_W     = $clog2(BANK_BEATS + 1);
    localparam int unsigned RES_W     = RES_ELEMS * ELEM_W;
    localparam int unsigned OUT_BEATS = RES_W / AXIS_W;
    localparam int unsigned OUT_W     = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CALC_WAIT,
        SEND
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [LAYER_W-1:0]     layers_q;
    logic [(2**LAYER_W)-1:0] mask_q;
    logic [LAYER_W-1:0]     layer;
    logic                   feedback;

    logic [1:0]             full;
    logic [CNT_W-1:0]       bank_beats [2];
    logic [1:0]             bank_last;
    logic                   wr_bank;
    logic                   rd_bank;
    logic [ADDR_W-1:0]      cnt;

    logic [OUT_W-1:0]       out_idx;
    logic                   m_valid;
    logic [RES_W-1:0]       fb_q;
    logic [RES_W-1:0]       relu_res;
    logic [AXIS_W-1:0]      out_beats [OUT_BEATS];

    logic                   wr_fire;
    logic                   bank_close;
    logic                   ack_fire;
    logic                   out_fire;
    logic                   out_final;

    assign cfg_ready     = (state == IDLE);
    assign s_axis_tready = (state == FILL) && !full[wr_bank];
    assign wr_fire       = s_axis_tvalid && s_axis_tready;
    assign bank_close    = (cnt == ADDR_W'(BANK_BEATS - 1)) || s_axis_tlast;
    assign ack_fire      = cu_bank_ack && full[rd_bank];
    assign out_fire      = m_valid && m_axis_tready;
    assign out_final     = (out_idx == OUT_W'(OUT_BEATS - 1));

    assign buf_wen       = wr_fire;
    assign buf_bank      = wr_bank;
    assign buf_waddr     = cnt;
    assign buf_wdata     = wr_fire ? s_axis_tdata : '0;

    assign cu_bank_valid = full[rd_bank];
    assign cu_bank       = rd_bank;
    assign cu_bank_beats = full[rd_bank] ? bank_beats[rd_bank] : '0;
    assign cu_bank_last  = full[rd_bank] && bank_last[rd_bank];
    assign cu_feedback   = feedback;
    assign fb_data       = fb_q;

    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = m_valid ? out_beats[out_idx] : '0;
    assign m_axis_tlast  = m_valid && out_final;

    // Next-state decode for the job sequencing FSM.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (cfg_valid) state_next = FILL;
            FILL:      if (wr_fire && s_axis_tlast) state_next = CALC_WAIT;
            CALC_WAIT: if (cu_done) state_next = (layer < layers_q) ? FILL : SEND;
            SEND:      if (out_fire && out_final) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Per-layer ReLU on the incoming result: negative elements (including -0) are zeroed.
    always_comb begin
        relu_res = cu_result;
        for (int unsigned e = 0; e < RES_ELEMS; e++) begin
            if (mask_q[layer] && cu_result[e*ELEM_W + ELEM_W - 1]) begin
                relu_res[e*ELEM_W +: ELEM_W] = '0;
            end
        end
    end

    // Split the feedback buffer into output beats, beat 0 in the low bits.
    always_comb begin
        for (int unsigned k = 0; k < OUT_BEATS; k++) begin
            out_beats[k] = fb_q[k*AXIS_W +: AXIS_W];
        end
    end

    // FSM state register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= IDLE;
        else              state <= state_next;
    end

    // Scratch pad bank bookkeeping: fill side closes banks, compute side acks them.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            full          <= '0;
            bank_beats[0] <= '0;
            bank_beats[1] <= '0;
            bank_last     <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            cnt           <= '0;
        end else begin
            if (wr_fire) begin
                if (bank_close) begin
                    full[wr_bank]       <= 1'b1;
                    bank_beats[wr_bank] <= CNT_W'(cnt) + 1'b1;
                    bank_last[wr_bank]  <= s_axis_tlast;
                    wr_bank             <= ~wr_bank;
                    cnt                 <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // A close can only target an empty bank and an ack only a full one,
            // so both updates in one cycle always touch different bits.
            if (ack_fire) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // Job configuration, layer chaining, feedback capture and result streaming.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            layers_q <= '0;
            mask_q   <= '0;
            layer    <= '0;
            feedback <= 1'b0;
            fb_q     <= '0;
            out_idx  <= '0;
            m_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        layers_q <= cfg_layers;
                        mask_q   <= cfg_relu_mask;
                        layer    <= '0;
                        feedback <= 1'b0;
                    end
                end
                CALC_WAIT: begin
                    if (cu_done) begin
                        fb_q <= relu_res;
                        if (layer < layers_q) begin
                            layer    <= layer + 1'b1;
                            feedback <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                    end else if (m_axis_tready) begin
                        if (out_final) begin
                            m_valid  <= 1'b0;
                            out_idx  <= '0;
                            feedback <= 1'b0;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ndp_stream_sequencer.sv
// Self-checking bench for ndp_stream_sequencer: table of jobs plus hand-written
// backpressure and reset sequences; bank and output scoreboards.
module tb_ndp_stream_sequencer;

    localparam int AXIS_W     = 32;
    localparam int ELEM_W     = 16;
    localparam int BANK_BEATS = 34;
    localparam int RES_ELEMS  = 64;
    localparam int LAYER_W    = 4;
    localparam int RES_W      = RES_ELEMS * ELEM_W;
    localparam int OUT_BEATS  = RES_W / AXIS_W;

    logic                   axi_aclk;
    logic                   axi_aresetn;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [LAYER_W-1:0]     cfg_layers;
    logic [(2**LAYER_W)-1:0] cfg_relu_mask;
    logic [AXIS_W-1:0]      s_axis_tdata;
    logic                   s_axis_tlast;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [AXIS_W-1:0]      m_axis_tdata;
    logic                   m_axis_tlast;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic                   buf_wen;
    logic                   buf_bank;
    logic [5:0]             buf_waddr;
    logic [AXIS_W-1:0]      buf_wdata;
    logic                   cu_bank_valid;
    logic                   cu_bank;
    logic [5:0]             cu_bank_beats;
    logic                   cu_bank_last;
    logic                   cu_bank_ack;
    logic                   cu_feedback;
    logic                   cu_done;
    logic [RES_W-1:0]       cu_result;
    logic [RES_W-1:0]       fb_data;

    ndp_stream_sequencer #(
        .AXIS_W     (AXIS_W),
        .ELEM_W     (ELEM_W),
        .BANK_BEATS (BANK_BEATS),
        .RES_ELEMS  (RES_ELEMS),
        .LAYER_W    (LAYER_W)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_layers    (cfg_layers),
        .cfg_relu_mask (cfg_relu_mask),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .buf_wen       (buf_wen),
        .buf_bank      (buf_bank),
        .buf_waddr     (buf_waddr),
        .buf_wdata     (buf_wdata),
        .cu_bank_valid (cu_bank_valid),
        .cu_bank       (cu_bank),
        .cu_bank_beats (cu_bank_beats),
        .cu_bank_last  (cu_bank_last),
        .cu_bank_ack   (cu_bank_ack),
        .cu_feedback   (cu_feedback),
        .cu_done       (cu_done),
        .cu_result     (cu_result),
        .fb_data       (fb_data)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    typedef struct {
        int          beats;
        bit          last;
    } bank_t;

    typedef struct {
        int          n_beats;
        int          wt_beats;
        int          layers;
        logic [15:0] mask;
        int          pat;
        int          tmode;
        int          exp_banks;
        int          exp_tail;
    } job_t;

    int               checks = 0;
    int               errors = 0;
    bank_t            bank_q[$];
    logic [AXIS_W-1:0] out_q[$];
    int               ack_budget = 1000000;
    int               banks_acked = 0;
    int               last_bank_beats = 0;
    int               tmode = 0;
    int               out_seen = 0;
    int               tlast_seen = 0;
    bit               stall_pending = 0;
    logic [AXIS_W-1:0] stall_data;
    logic             stall_last;
    int               exp_cnt = 0;
    bit               exp_bank = 0;
    bit               exp_rd = 0;
    logic [RES_W-1:0] exp_fb = '0;
    logic [5:0]       last_waddr;
    logic             last_bank;
    job_t             jobs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int e = 0; e < RES_ELEMS; e++) begin
                if (act[e*ELEM_W +: ELEM_W] !== exp[e*ELEM_W +: ELEM_W]) begin
                    $display("FAIL %s elem %0d: got %h expected %h", name, e,
                             act[e*ELEM_W +: ELEM_W], exp[e*ELEM_W +: ELEM_W]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [RES_W-1:0] make_result(input int pat, input int layer);
        logic [RES_W-1:0] r;
        logic [15:0]      v;
        for (int e = 0; e < RES_ELEMS; e++) begin
            if (pat == 0)        v = 16'(e);
            else if (e % 4 == 0) v = 16'hBC00;
            else if (e % 4 == 1) v = 16'h8000;
            else                 v = 16'(e + 256 * layer + 7);
            r[e*ELEM_W +: ELEM_W] = v;
        end
        return r;
    endfunction

    function automatic logic [RES_W-1:0] relu(input logic [RES_W-1:0] v, input bit en);
        logic [RES_W-1:0] r;
        r = v;
        for (int e = 0; e < RES_ELEMS; e++)
            if (en && v[e*ELEM_W + ELEM_W - 1]) r[e*ELEM_W +: ELEM_W] = '0;
        return r;
    endfunction

    // Compute-unit model: acks each offered bank and checks it against the bank scoreboard.
    initial begin
        bank_t b;
        cu_bank_ack = 1'b0;
        forever begin
            @(negedge axi_aclk);
            cu_bank_ack = 1'b0;
            if (axi_aresetn && cu_bank_valid === 1'b1 && ack_budget > 0) begin
                if (bank_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bank_unexpected: got bank %0d expected none", cu_bank);
                end else begin
                    b = bank_q.pop_front();
                    chk("bank_beats", cu_bank_beats, b.beats);
                    chk("bank_last", cu_bank_last, b.last);
                end
                chk("cu_bank", cu_bank, exp_rd);
                exp_rd = ~exp_rd;
                banks_acked++;
                last_bank_beats = cu_bank_beats;
                ack_budget--;
                cu_bank_ack = 1'b1;
            end
        end
    end

    // m_axis sink readiness: always ready, or ready one cycle in three.
    initial begin
        int cyc;
        cyc = 0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge axi_aclk);
            cyc++;
            m_axis_tready = (tmode == 0) ? 1'b1 : (cyc % 3 == 0);
        end
    end

    // Output monitor: pops expected beats, checks ordering, tlast and stall stability.
    initial begin
        logic [AXIS_W-1:0] e;
        forever begin
            @(negedge axi_aclk);
            #2;
            if (!axi_aresetn) begin
                stall_pending = 0;
            end else if (m_axis_tvalid === 1'b1) begin
                if (stall_pending) begin
                    chk("stall_data", m_axis_tdata, stall_data);
                    chk("stall_last", m_axis_tlast, stall_last);
                end
                if (m_axis_tready) begin
                    if (out_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got %h expected none", m_axis_tdata);
                    end else begin
                        e = out_q.pop_front();
                        chk("out_data", m_axis_tdata, e);
                    end
                    chk("out_last", m_axis_tlast, out_seen == OUT_BEATS - 1);
                    out_seen++;
                    if (m_axis_tlast) tlast_seen++;
                    stall_pending = 0;
                end else begin
                    stall_pending = 1;
                    stall_data    = m_axis_tdata;
                    stall_last    = m_axis_tlast;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic send_beats(input int n, input int base, input bit last_at_end);
        for (int i = 0; i < n; i++) begin
            int waits;
            waits = 0;
            @(negedge axi_aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = AXIS_W'(base + i);
            s_axis_tlast  = last_at_end && (i == n - 1);
            #1;
            while (s_axis_tready !== 1'b1 && waits < 500) begin
                @(negedge axi_aclk);
                #1;
                waits++;
            end
            if (waits >= 500) begin
                checks++;
                errors++;
                $display("FAIL s_axis_timeout: got tready=0 expected tready=1");
                s_axis_tvalid = 1'b0;
                return;
            end
            chk("buf_wen", buf_wen, 1);
            chk("buf_bank", buf_bank, exp_bank);
            chk("buf_waddr", buf_waddr, exp_cnt);
            chk("buf_wdata", buf_wdata, s_axis_tdata);
            last_waddr = buf_waddr;
            last_bank  = buf_bank;
            exp_cnt++;
            if (exp_cnt == BANK_BEATS || s_axis_tlast) begin
                bank_q.push_back('{exp_cnt, s_axis_tlast});
                exp_cnt  = 0;
                exp_bank = ~exp_bank;
            end
        end
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_banks_acked();
        int w;
        w = 0;
        while ((bank_q.size() != 0 || cu_bank_valid === 1'b1) && w < 1000) begin
            @(negedge axi_aclk);
            w++;
        end
        if (w >= 1000) begin
            checks++;
            errors++;
            $display("FAIL bank_drain_timeout: got %0d pending expected 0", bank_q.size());
        end
    endtask

    task automatic start_job(input int layers, input logic [15:0] mask, input int mode);
        int w;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 2000) begin
            @(negedge axi_aclk);
            w++;
        end
        chk("cfg_ready_idle", cfg_ready, 1);
        @(negedge axi_aclk);
        cfg_valid     = 1'b1;
        cfg_layers    = LAYER_W'(layers);
        cfg_relu_mask = mask;
        tmode         = mode;
        out_seen      = 0;
        tlast_seen    = 0;
        @(negedge axi_aclk);
        cfg_valid = 1'b0;
        #1;
        chk("cfg_ready_busy", cfg_ready, 0);
    endtask

    task automatic finish_layer(input logic [RES_W-1:0] r, input bit relu_en, input bit is_last,
                                input bit exp_feedback);
        exp_fb = relu(r, relu_en);
        if (is_last)
            for (int k = 0; k < OUT_BEATS; k++) out_q.push_back(exp_fb[k*AXIS_W +: AXIS_W]);
        @(negedge axi_aclk);
        cu_done   = 1'b1;
        cu_result = r;
        @(negedge axi_aclk);
        cu_done = 1'b0;
        #1;
        chk_vec("fb_data", fb_data, exp_fb);
        chk("cu_feedback", cu_feedback, exp_feedback);
    endtask

    task automatic finish_job();
        int w;
        w = 0;
        while ((out_q.size() != 0 || cfg_ready !== 1'b1) && w < 2000) begin
            @(negedge axi_aclk);
            w++;
        end
        #3;
        chk("out_beats", out_seen, OUT_BEATS);
        chk("tlast_count", tlast_seen, 1);
        chk("tvalid_after", m_axis_tvalid, 0);
        chk("feedback_after", cu_feedback, 0);
    endtask

    task automatic run_job(input job_t j);
        logic [RES_W-1:0] r;
        start_job(j.layers, j.mask, j.tmode);
        for (int l = 0; l <= j.layers; l++) begin
            banks_acked = 0;
            send_beats((l == 0) ? j.n_beats : j.wt_beats, (l + 1) * 32'h0001_0000, 1'b1);
            wait_banks_acked();
            if (l == 0) begin
                chk("bank_count", banks_acked, j.exp_banks);
                chk("tail_beats", last_bank_beats, j.exp_tail);
            end
            r = make_result(j.pat, l);
            finish_layer(r, j.mask[l], l == j.layers, j.layers != 0);
            if (j.pat == 1 && l == 0 && j.layers != 0 && !j.mask[0])
                chk("fb_keep_neg", fb_data[15:0], 16'hBC00);
        end
        finish_job();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_m_tlast", m_axis_tlast, 0);
        chk("rst_buf_wen", buf_wen, 0);
        chk("rst_buf_bank", buf_bank, 0);
        chk("rst_buf_waddr", buf_waddr, 0);
        chk("rst_buf_wdata", buf_wdata, 0);
        chk("rst_cu_valid", cu_bank_valid, 0);
        chk("rst_cu_bank", cu_bank, 0);
        chk("rst_cu_beats", cu_bank_beats, 0);
        chk("rst_cu_last", cu_bank_last, 0);
        chk("rst_cu_feedback", cu_feedback, 0);
        chk_vec("rst_fb_data", fb_data, '0);
    endtask

    task automatic clear_model();
        exp_cnt  = 0;
        exp_bank = 0;
        exp_rd   = 0;
        exp_fb   = '0;
        bank_q.delete();
        out_q.delete();
    endtask

    initial begin
        logic [RES_W-1:0] r;
        // n_beats wt_beats layers mask pat tmode exp_banks exp_tail
        jobs[0] = '{68, 0,  0, 16'h0000, 0, 0, 2, 34};
        jobs[1] = '{40, 0,  0, 16'h0000, 0, 0, 2, 6};
        jobs[2] = '{20, 10, 1, 16'h0002, 1, 0, 1, 20};
        jobs[3] = '{68, 0,  0, 16'h0001, 1, 1, 2, 34};
        jobs[4] = '{34, 0,  0, 16'h0000, 0, 1, 1, 34};

        axi_aresetn   = 1'b1;
        cfg_valid     = 1'b0;
        cfg_layers    = '0;
        cfg_relu_mask = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b0;
        cu_done       = 1'b0;
        cu_result     = '0;
        #2;
        axi_aresetn = 1'b0;
        repeat (3) @(negedge axi_aclk);
        #1;
        chk_reset_outputs();
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;

        foreach (jobs[i]) run_job(jobs[i]);

        // Reset in the middle of a fill aborts the job; the next job runs cleanly.
        start_job(0, 16'h0000, 0);
        send_beats(10, 32'h00AA_0000, 1'b0);
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEAD_BEEF;
        axi_aresetn   = 1'b0;
        clear_model();
        #1;
        s_axis_tvalid = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        run_job(jobs[0]);

        // Both banks full with no acks: stream stalls, one ack frees bank 0 at address 0.
        start_job(0, 16'h0000, 0);
        ack_budget = 0;
        send_beats(2 * BANK_BEATS, 32'h00BB_0000, 1'b0);
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h00BB_0044;
        s_axis_tlast  = 1'b1;
        cu_done       = 1'b1;
        cu_result     = '1;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("bp_tready", s_axis_tready, 0);
            chk("bp_wen", buf_wen, 0);
            @(negedge axi_aclk);
            cu_done = 1'b0;
            #1;
        end
        chk("bp_cu_valid", cu_bank_valid, 1);
        chk("bp_cu_bank", cu_bank, 0);
        chk_vec("fb_ignore_done", fb_data, exp_fb);
        ack_budget = 1;
        send_beats(1, 32'h00BB_0044, 1'b1);
        chk("bp_waddr", last_waddr, 0);
        chk("bp_bank", last_bank, 0);
        ack_budget = 1000000;
        wait_banks_acked();
        r = make_result(0, 0);
        finish_layer(r, 1'b0, 1'b1, 1'b0);
        finish_job();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
